// File: rtl/vga_frame_checker.sv
// Frame checker for the VGA pixel stream: compares in-window pixels against an
// expected ready/valid stream and folds them into a rotate-XOR 32-bit signature.
module vga_frame_checker #(
  parameter int NUM_CH         = 3,
  parameter int CH_WIDTH       = 8,
  parameter int VIEW_LEFT      = 160,
  parameter int VIEW_RIGHT     = 480,
  parameter int VIEW_TOP       = 120,
  parameter int VIEW_BOTTOM    = 360,
  parameter int MAX_MISMATCHES = 10
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       vsync_n,
  input  logic                       pixel_valid,
  input  logic [9:0]                 pixel_x,
  input  logic [9:0]                 pixel_y,
  input  logic [NUM_CH*CH_WIDTH-1:0] pixel_data,
  input  logic [NUM_CH*CH_WIDTH-1:0] exp_data,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic                       underflow,
  output logic [15:0]                mismatch_count,
  output logic [9:0]                 first_err_x,
  output logic [9:0]                 first_err_y,
  output logic [17:0]                pixel_count,
  output logic [31:0]                signature
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LOW  = 3'd1;
  localparam logic [2:0] S_WAIT_HIGH = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        mode_q, mode_d;
  logic        vsync_prev_q;
  logic        aborted_q, aborted_d;
  logic        underflow_q, underflow_d;
  logic [15:0] mm_q, mm_d;
  logic [9:0]  fx_q, fx_d, fy_q, fy_d;
  logic [17:0] pc_q, pc_d;
  logic [31:0] sig_q, sig_d;

  logic [NUM_CH-1:0] ch_ne;
  logic [15:0]       ne_cnt;
  logic [16:0]       mm_sum;
  logic              in_win, hit, cmp;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_ne[c] = pixel_data[c*CH_WIDTH +: CH_WIDTH] != exp_data[c*CH_WIDTH +: CH_WIDTH];
  end

  always_comb begin
    ne_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) ne_cnt = ne_cnt + 16'(ch_ne[c]);
  end

  assign in_win = (32'(pixel_x) >= VIEW_LEFT) && (32'(pixel_x) < VIEW_RIGHT) &&
                  (32'(pixel_y) >= VIEW_TOP)  && (32'(pixel_y) < VIEW_BOTTOM);
  assign hit    = (state_q == S_CHECK) && pixel_valid && in_win;
  assign cmp    = hit && !mode_q && exp_valid;
  assign mm_sum = {1'b0, mm_q} + {1'b0, ne_cnt};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    aborted_d   = aborted_q;
    underflow_d = underflow_q;
    mm_d        = mm_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    pc_d        = pc_q;
    sig_d       = sig_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_WAIT_LOW;
        mode_d      = mode;
        aborted_d   = 1'b0;
        underflow_d = 1'b0;
        mm_d        = '0;
        fx_d        = 10'h3FF;
        fy_d        = 10'h3FF;
        pc_d        = '0;
        sig_d       = '0;
      end
      S_WAIT_LOW:  if (!vsync_n) state_d = S_WAIT_HIGH;
      S_WAIT_HIGH: if (vsync_n)  state_d = S_CHECK;
      S_CHECK: begin
        // abort looks at the registered count, so it lands one cycle after the hit
        if (32'(mm_q) > MAX_MISMATCHES) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (vsync_prev_q && !vsync_n) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (hit) begin
      pc_d  = pc_q + 18'd1;
      sig_d = {sig_q[30:0], sig_q[31]} ^ 32'(pixel_data);
      if (!mode_q) begin
        if (exp_valid) begin
          mm_d = mm_sum[16] ? 16'hFFFF : mm_sum[15:0];
          // count saturates and never wraps, so zero means no error seen yet
          if (ne_cnt != 16'd0 && mm_q == 16'd0) begin
            fx_d = pixel_x;
            fy_d = pixel_y;
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      vsync_prev_q <= 1'b1;
      aborted_q    <= 1'b0;
      underflow_q  <= 1'b0;
      mm_q         <= '0;
      fx_q         <= 10'h3FF;
      fy_q         <= 10'h3FF;
      pc_q         <= '0;
      sig_q        <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      vsync_prev_q <= vsync_n;
      aborted_q    <= aborted_d;
      underflow_q  <= underflow_d;
      mm_q         <= mm_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      pc_q         <= pc_d;
      sig_q        <= sig_d;
    end
  end

  assign exp_ready      = cmp;
  assign busy           = (state_q == S_WAIT_LOW) || (state_q == S_WAIT_HIGH) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign aborted        = aborted_q;
  assign underflow      = underflow_q;
  assign mismatch_count = mm_q;
  assign first_err_x    = fx_q;
  assign first_err_y    = fy_q;
  assign pixel_count    = pc_q;
  assign signature      = sig_q;
endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker on a tiny 8x4 raster with a 4x2 view window.
// Expected frame results are queued per start and checked when done pulses.
module tb_vga_frame_checker;
  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0, mode = 1'b0, vsync_n = 1'b1, pixel_valid = 1'b0, exp_valid = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [23:0] pixel_data = '0, exp_data = '0;

  logic        exp_ready, busy, done, aborted, underflow;
  logic [15:0] mismatch_count;
  logic [9:0]  first_err_x, first_err_y;
  logic [17:0] pixel_count;
  logic [31:0] signature;
  logic        exp_ready_a, busy_a, done_a, aborted_a, underflow_a;
  logic [15:0] mismatch_count_a;
  logic [9:0]  first_err_x_a, first_err_y_a;
  logic [17:0] pixel_count_a;
  logic [31:0] signature_a;

  typedef struct {
    logic [17:0] pc;
    logic [15:0] mm;
    logic [9:0]  fx, fy;
    logic        ab, uf;
    logic [31:0] sig;
    int          rdy;
  } exp_t;

  exp_t q[$];
  exp_t q_a[$];
  int   checks = 0, errors = 0;
  int   rdy_cnt = 0;
  bit   done_a_seen = 0;

  always #10 Clock = ~Clock;

  vga_frame_checker #(.VIEW_LEFT(2), .VIEW_RIGHT(6), .VIEW_TOP(1), .VIEW_BOTTOM(3),
                      .MAX_MISMATCHES(10)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .mode(mode), .vsync_n(vsync_n),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .exp_data(exp_data), .exp_valid(exp_valid),
    .exp_ready(exp_ready), .busy(busy), .done(done), .aborted(aborted), .underflow(underflow),
    .mismatch_count(mismatch_count), .first_err_x(first_err_x), .first_err_y(first_err_y),
    .pixel_count(pixel_count), .signature(signature));

  vga_frame_checker #(.VIEW_LEFT(2), .VIEW_RIGHT(6), .VIEW_TOP(1), .VIEW_BOTTOM(3),
                      .MAX_MISMATCHES(2)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .start(start), .mode(mode), .vsync_n(vsync_n),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_data(pixel_data), .exp_data(exp_data), .exp_valid(exp_valid),
    .exp_ready(exp_ready_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
    .underflow(underflow_a), .mismatch_count(mismatch_count_a),
    .first_err_x(first_err_x_a), .first_err_y(first_err_y_a),
    .pixel_count(pixel_count_a), .signature(signature_a));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit inwin(int x, int y);
    return x >= 2 && x < 6 && y >= 1 && y < 3;
  endfunction

  function automatic logic [23:0] pix_of(int t, int x, int y, int idx);
    if (t == 5 && inwin(x, y)) return 24'(idx);
    return {8'(x * 16 + y), 8'(y * 3 + x + 1), 8'((x ^ y) + 5)};
  endfunction

  function automatic logic [23:0] exp_of(int t, int x, int y, logic [23:0] p);
    logic [23:0] e;
    e = p;
    if (t == 2 && x == 3 && y == 2) e[15:8] = p[15:8] + 8'd1;
    if (t == 2 && x == 5 && y == 2) e = ~p;
    if (t == 3 && x == 2 && y == 1) e = ~p;
    return e;
  endfunction

  function automatic bit ev_of(int t, int x, int y);
    return !(t == 4 && x == 4 && y == 1);
  endfunction

  always @(negedge Clock) begin
    exp_t e;
    if (exp_ready) rdy_cnt++;
    if (done) begin
      chk("done_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pixel_count", 64'(pixel_count), 64'(e.pc));
        chk("mismatch_count", 64'(mismatch_count), 64'(e.mm));
        chk("first_err_x", 64'(first_err_x), 64'(e.fx));
        chk("first_err_y", 64'(first_err_y), 64'(e.fy));
        chk("aborted", 64'(aborted), 64'(e.ab));
        chk("underflow", 64'(underflow), 64'(e.uf));
        chk("signature", 64'(signature), 64'(e.sig));
        chk("exp_ready_cycles", 64'(rdy_cnt), 64'(e.rdy));
      end
    end
    if (done_a) begin
      done_a_seen = 1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_pixel_count", 64'(pixel_count_a), 64'(e.pc));
        chk("a_mismatch_count", 64'(mismatch_count_a), 64'(e.mm));
        chk("a_first_err_x", 64'(first_err_x_a), 64'(e.fx));
        chk("a_aborted", 64'(aborted_a), 64'(e.ab));
        chk("a_signature", 64'(signature_a), 64'(e.sig));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic arm(input bit m);
    tick();
    start = 1; mode = m;
    tick();
    start = 0; mode = 0;
    vsync_n = 0;
    repeat (3) tick();
    vsync_n = 1;
    tick();
  endtask

  // One full frame of test t; model results for both instances are queued before driving.
  task automatic frame(input bit m, input int t, input bit push_a);
    exp_t e[2];
    int   mx[2];
    int   idx, n;
    logic [23:0] p, ex;
    bit   ev;
    mx[0] = 10; mx[1] = 2;
    for (int k = 0; k < 2; k++) begin
      e[k].pc = 0; e[k].mm = 0; e[k].fx = 10'h3FF; e[k].fy = 10'h3FF;
      e[k].ab = 0; e[k].uf = 0; e[k].sig = 0; e[k].rdy = 0;
    end
    idx = 0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        if (inwin(x, y)) begin
          idx++;
          p = pix_of(t, x, y, idx); ex = exp_of(t, x, y, p); ev = ev_of(t, x, y);
          for (int k = 0; k < 2; k++)
            if (!(int'(e[k].mm) > mx[k])) begin
              e[k].pc++;
              e[k].sig = {e[k].sig[30:0], e[k].sig[31]} ^ {8'd0, p};
              if (!m) begin
                if (ev) begin
                  e[k].rdy++;
                  n = 0;
                  for (int c = 0; c < 3; c++) if (p[c*8 +: 8] != ex[c*8 +: 8]) n++;
                  if (n != 0 && e[k].mm == 0) begin e[k].fx = 10'(x); e[k].fy = 10'(y); end
                  e[k].mm = e[k].mm + 16'(n);
                end else e[k].uf = 1;
              end
              if (int'(e[k].mm) > mx[k]) e[k].ab = 1;
            end
        end
    q.push_back(e[0]);
    if (push_a) q_a.push_back(e[1]);

    rdy_cnt = 0; done_a_seen = 0;
    arm(m);
    exp_valid = 1;
    idx = 0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        if (inwin(x, y)) idx++;
        p = pix_of(t, x, y, idx);
        pixel_x = 10'(x); pixel_y = 10'(y);
        pixel_data = p; exp_data = exp_of(t, x, y, p); exp_valid = ev_of(t, x, y);
        pixel_valid = 1;
        tick();
        pixel_valid = 0; exp_valid = 1;
        tick();
      end
    if (push_a) chk("abort_before_frame_end", 64'(done_a_seen), 64'd1);
    vsync_n = 0;
    repeat (3) tick();
    vsync_n = 1;
    for (int i = 0; i < 20 && (q.size() + q_a.size()) > 0; i++) tick();
    chk("done_timeout_pending", 64'(q.size() + q_a.size()), 64'd0);
    q.delete(); q_a.delete();
    exp_valid = 0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_aborted"}, 64'(aborted), 64'd0);
    chk({pfx, "_underflow"}, 64'(underflow), 64'd0);
    chk({pfx, "_mm"}, 64'(mismatch_count), 64'd0);
    chk({pfx, "_fx"}, 64'(first_err_x), 64'h3FF);
    chk({pfx, "_fy"}, 64'(first_err_y), 64'h3FF);
    chk({pfx, "_pc"}, 64'(pixel_count), 64'd0);
    chk({pfx, "_sig"}, 64'(signature), 64'd0);
    chk({pfx, "_exp_ready"}, 64'(exp_ready), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    chk_reset_vals("rst");
    tick();
    Resetn = 1;
    tick();

    frame(0, 1, 0);  // all match
    frame(0, 2, 0);  // 4 channel mismatches, first at (3,2)
    frame(0, 3, 1);  // low-limit instance aborts on first pixel
    frame(0, 4, 0);  // expected stream starved for one pixel
    frame(1, 5, 0);  // signature only, mode input dropped after start

    // reset in the middle of a check: no done may follow
    rdy_cnt = 0;
    arm(0);
    exp_valid = 1;
    for (int x = 2; x < 5; x++) begin
      pixel_x = 10'(x); pixel_y = 10'd1; pixel_data = 24'h123456; exp_data = 24'h123456;
      pixel_valid = 1;
      tick();
      pixel_valid = 0;
      tick();
    end
    Resetn = 0;
    @(negedge Clock);
    chk_reset_vals("midrst");
    tick();
    Resetn = 1;
    vsync_n = 0;
    repeat (3) tick();
    vsync_n = 1;
    repeat (5) tick();
    @(negedge Clock);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_pc", 64'(pixel_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
